// File: rtl/mult_unit.sv
// mult_unit: iterative shift-add multiplier for the MIPS ALU datapath.
// Handles MULT (signed) and MULTU (unsigned). Each iteration adds one partial
// product through a carry-select adder. A sign fix-up is then applied before
// the 2*WIDTH-bit product is written to the HI/LO result registers.

// Carry-select adder: ripple within each block, with both carry-in
// hypotheses precomputed. The real carry then selects the block result.
module mult_csel_adder #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    localparam int NBLK = WIDTH / BLK;

    logic [NBLK:0] c;

    assign c[0] = cin_i;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [BLK:0] s0;
        logic [BLK:0] s1;
        assign s0 = {1'b0, a_i[g*BLK +: BLK]} + {1'b0, b_i[g*BLK +: BLK]};
        assign s1 = s0 + (BLK+1)'(1);
        assign sum_o[g*BLK +: BLK] = c[g] ? s1[BLK-1:0] : s0[BLK-1:0];
        assign c[g+1] = c[g] ? s1[BLK] : s0[BLK];
    end

    assign cout_o = c[NBLK];
endmodule

module mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;

    // Datapath registers: multiplicand, upper accumulator half, and the
    // multiplier register, which fills with low product bits as it shifts.
    logic [WIDTH-1:0]   mcand_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic               neg_q;

    logic [WIDTH-1:0]   add_b_d;
    logic [WIDTH-1:0]   add_sum_d;
    logic               add_cout_d;
    logic [2*WIDTH-1:0] prod_d;

    // Magnitude of an operand; the most negative value maps onto 2^(WIDTH-1).
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic sgn);
        return (sgn && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    // Two's complement of the full-width product.
    function automatic logic [2*WIDTH-1:0] negate_prod(input logic [2*WIDTH-1:0] v);
        return ~v + (2*WIDTH)'(1);
    endfunction

    // The partial product is either the multiplicand or zero, chosen by the
    // multiplier LSB.
    always_comb begin
        add_b_d = mplier_q[0] ? mcand_q : '0;
        prod_d  = {acc_q, mplier_q};
    end

    mult_csel_adder #(
        .WIDTH (WIDTH),
        .BLK   (8)
    ) u_adder (
        .a_i    (acc_q),
        .b_i    (add_b_d),
        .cin_i  (1'b0),
        .sum_o  (add_sum_d),
        .cout_o (add_cout_d)
    );

    // Datapath: capture magnitudes on start, then shift {carry, sum, multiplier} right each iteration.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && start) begin
            mcand_q  <= magnitude(op_a, is_signed);
            mplier_q <= magnitude(op_b, is_signed);
            acc_q    <= '0;
            neg_q    <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
        end else if (state_q == S_ITER) begin
            acc_q    <= {add_cout_d, add_sum_d[WIDTH-1:1]};
            mplier_q <= {add_sum_d[0], mplier_q[WIDTH-1:1]};
        end
    end

    // Control FSM with registered busy/done and the HI/LO result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= S_ITER;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                S_ITER: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    {hi_q, lo_q} <= neg_q ? negate_prod(prod_d) : prod_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;
endmodule

// File: tb/tb_mult_unit.sv
// tb_mult_unit: directed, table-driven bench for mult_unit, plus hand-written
// sequences for start-while-busy, back-to-back starts and reset mid-operation.
module tb_mult_unit;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t vecs [12];

    mult_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // One full operation. It checks latency, busy duration, HI/LO hold and the
    // result. A nonzero inj_at pulses start with other operands on edge T0+inj_at.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                          input logic [31:0] ph, input logic [31:0] pl, input int inj_at);
        int   cyc;
        int   busy_n;
        logic hold_ok;
        @(negedge clk);
        start = 1'b1; is_signed = sgn; op_a = a; op_b = b;
        @(posedge clk); #1;
        start = 1'b0; is_signed = ~sgn; op_a = ~a; op_b = b ^ 32'h5A5A5A5A;
        cyc = 0; busy_n = 0; hold_ok = 1'b1;
        while (!done && cyc < 100) begin
            if (busy) busy_n++;
            if (hi !== ph || lo !== pl) hold_ok = 1'b0;
            if (cyc == inj_at - 1) begin
                start = 1'b1; is_signed = 1'b0; op_a = 32'd100; op_b = 32'd100;
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
        end
        chk({name, " latency"}, 32'(cyc), 32'd33);
        chk({name, " busy cycles"}, 32'(busy_n), 32'd33);
        chk({name, " hold"}, {31'd0, hold_ok}, 32'd1);
        chk({name, " busy at done"}, {31'd0, busy}, 32'd0);
        chk({name, " hi"}, hi, eh);
        chk({name, " lo"}, lo, el);
        @(posedge clk); #1;
        chk({name, " done pulse width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int          cyc;
        int          done_seen;
        logic [31:0] ph;
        logic [31:0] pl;

        vecs[0]  = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[2]  = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
        vecs[3]  = '{1'b1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[4]  = '{1'b0, 32'hFFFFFFFD, 32'h00000007, 32'h00000006, 32'hFFFFFFEB};
        vecs[5]  = '{1'b0, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
        vecs[6]  = '{1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
        vecs[7]  = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[8]  = '{1'b0, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[9]  = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[10] = '{1'b0, 32'h12345678, 32'h00000002, 32'h00000000, 32'h2468ACF0};
        vecs[11] = '{1'b1, 32'h00000003, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFA};

        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset hi", hi, 32'd0);
        chk("reset lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of single operations; each must hold the previous result until its own done.
        ph = 32'd0; pl = 32'd0;
        for (int i = 0; i < 12; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].sgn, vecs[i].a, vecs[i].b,
                   vecs[i].eh, vecs[i].el, ph, pl, 0);
            ph = vecs[i].eh; pl = vecs[i].el;
        end

        // Start pulsed at T0+10 while busy must be ignored: 5*6 = 30.
        run_op("ignore start", 1'b1, 32'd5, 32'd6, 32'd0, 32'd30, ph, pl, 10);
        ph = 32'd0; pl = 32'd30;

        // Start held high: 3*4 finishes at T0+33, 9*9 is sampled at T0+34, and it finishes at T0+67.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("b2b first latency", 32'(cyc), 32'd33);
        chk("b2b first lo", lo, 32'd12);
        op_a = 32'd9; op_b = 32'd9;
        @(posedge clk); #1;
        cyc++;
        op_a = 32'hDEADBEEF; op_b = 32'hCAFEF00D;
        while (!done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        chk("b2b second latency", 32'(cyc), 32'd67);
        chk("b2b second hi", hi, 32'd0);
        chk("b2b second lo", lo, 32'd81);
        repeat (3) @(posedge clk);

        // Reset at T0+15 discards the operation without a done pulse.
        @(negedge clk);
        start = 1'b1; is_signed = 1'b0; op_a = 32'hFFFFFFFF; op_b = 32'hFFFFFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset hi", hi, 32'd0);
        chk("midreset lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (done || busy) done_seen++;
        end
        chk("midreset no done", 32'(done_seen), 32'd0);

        run_op("after reset", 1'b0, 32'd6, 32'd7, 32'd0, 32'd42, 32'd0, 32'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
